// File: rtl/down_counter_timer_pkg.sv
// down_counter_timer_pkg: shared state encoding for the down-counter timer.
package down_counter_timer_pkg;
   localparam int STATE_W = 2;
   typedef enum logic [STATE_W-1:0] {IDLE, RUN, HOLD} state_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits one tick every PRESCALE cycles while run is high; clear restarts the period.
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic tick
);
   generate
      if (PRESCALE == 1) begin : g_bypass
         logic unused;
         assign unused = ^{clk, reset, clear};
         assign tick = run;
      end else begin : g_cnt
         localparam int CW = $clog2(PRESCALE);
         logic [CW-1:0] cnt;
         assign tick = run && cnt == '0;
         always_ff @(posedge clk)
            if (!reset || clear) cnt <= CW'(PRESCALE - 1);
            else if (run) cnt <= tick ? CW'(PRESCALE - 1) : cnt - 1'b1;
      end
   endgenerate
endmodule

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter timer with pause, prescaler and terminal-count pulse.
// Define AUTO_RELOAD_EN to restart from the loaded value at terminal count instead of stopping.
module down_counter_timer
   import down_counter_timer_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             tc
);
   state_t           state, state_next;
   logic [WIDTH-1:0] q_next;
   logic             tc_next, tick;
   tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (load || state == IDLE),
      .run   (state != IDLE && !pause),
      .tick  (tick)
   );
`ifdef AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload;
   always_ff @(posedge clk)
      if (!reset) reload <= '0;
      else if (load) reload <= load_val;
`endif
   always_ff @(posedge clk)
      if (!reset) begin
         state <= IDLE;
         q     <= '0;
         tc    <= 1'b0;
      end else begin
         state <= state_next;
         q     <= q_next;
         tc    <= tc_next;
      end
   always_comb begin
      state_next = state;
      q_next     = q;
      tc_next    = 1'b0;
      if (load) begin
         state_next = IDLE;
         q_next     = load_val;
      end else if (state == IDLE) begin
         if (start && !pause && q != '0) state_next = RUN;
      end else if (pause) begin
         state_next = HOLD;
      end else begin
         state_next = RUN;
         if (tick) begin
            q_next = q - 1'b1;
            if (q == WIDTH'(1)) begin
               tc_next = 1'b1;
`ifdef AUTO_RELOAD_EN
               if (reload != '0) q_next = reload;
               else state_next = IDLE;
`else
               state_next = IDLE;
`endif
            end
         end
      end
   end
   assign busy = state != IDLE;
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: randomized scoreboard bench driving PRESCALE=1 and PRESCALE=3 timers in parallel.
module tb_down_counter_timer;
`ifdef AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   typedef struct {
      bit run;
      bit tc;
      int q;
      int base;
      int elapsed;
      int reload;
   } model_t;
   typedef struct {
      logic [3:0] q;
      logic       busy;
      logic       tc;
   } exp_t;
   logic       clk = 1'b0;
   logic       reset = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] q1, q3;
   logic       busy1, busy3, tc1, tc3;
   model_t     m1, m3;
   exp_t       sb1[$], sb3[$];
   int         checks = 0, fails = 0;
   always #5 clk = ~clk;
   down_counter_timer #(.WIDTH(4), .PRESCALE(1)) u_p1 (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .q(q1), .busy(busy1), .tc(tc1)
   );
   down_counter_timer #(.WIDTH(4), .PRESCALE(3)) u_p3 (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .q(q3), .busy(busy3), .tc(tc3)
   );
   // Expected count is derived from elapsed run cycles: q = L - elapsed/P, terminal at L*P.
   function automatic model_t step(input model_t m, input int p, input logic r, ld,
                                   input logic [3:0] lv, input logic st, ps);
      m.tc = 1'b0;
      if (!r) begin
         m.run = 1'b0; m.q = 0; m.reload = 0;
      end else if (ld) begin
         m.run = 1'b0; m.q = int'(lv); m.reload = int'(lv);
      end else if (!m.run) begin
         if (st && !ps && m.q != 0) begin
            m.run = 1'b1; m.base = m.q; m.elapsed = 0;
         end
      end else if (!ps) begin
         m.elapsed++;
         m.q = m.base - m.elapsed / p;
         if (m.elapsed == m.base * p) begin
            m.tc = 1'b1;
            if (AUTO && m.reload != 0) begin
               m.base = m.reload; m.elapsed = 0; m.q = m.reload;
            end else begin
               m.run = 1'b0; m.q = 0;
            end
         end
      end
      return m;
   endfunction
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask
   task automatic cyc(input logic r, ld, input logic [3:0] lv, input logic st, ps);
      @(negedge clk);
      reset = r; load = ld; load_val = lv; start = st; pause = ps;
      m1 = step(m1, 1, r, ld, lv, st, ps);
      m3 = step(m3, 3, r, ld, lv, st, ps);
      sb1.push_back('{q: 4'(m1.q), busy: m1.run, tc: m1.tc});
      sb3.push_back('{q: 4'(m3.q), busy: m3.run, tc: m3.tc});
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("p1_q", int'(q1), int'(e.q));
            chk("p1_busy", int'(busy1), int'(e.busy));
            chk("p1_tc", int'(tc1), int'(e.tc));
         end
         if (sb3.size() > 0) begin
            e = sb3.pop_front();
            chk("p3_q", int'(q3), int'(e.q));
            chk("p3_busy", int'(busy3), int'(e.busy));
            chk("p3_tc", int'(tc3), int'(e.tc));
         end
      end
   end
   initial begin
      m1 = '{default: 0};
      m3 = '{default: 0};
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      idle(18);
      cyc(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      idle(9);
      cyc(1'b1, 1'b1, 4'd6, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      idle(2);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      idle(20);
      cyc(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      idle(2);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      idle(2);
      cyc(1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      idle(2);
      cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      idle(30);
      cyc(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      idle(12);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(63) != 0, $urandom_range(15) == 0, 4'($urandom_range(15)),
             $urandom_range(3) == 0, $urandom_range(5) == 0);
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drain", sb1.size() + sb3.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
